// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file.
// The writable() predicate is the single definition of a legal write or read target.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_NUM_RD = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // True when addr names a real, non-hardwired register.
  function automatic logic writable(input int unsigned addr, input int unsigned depth,
                                    input bit zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: range/zero qualification, write-to-read bypass, optional output register.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          REG_OUT  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic              rd_valid;
  logic              wr0_hit;
  logic              wr1_hit;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rd_valid = writable(32'(raddr_i), DEPTH, ZERO_REG);
    wr0_hit  = BYPASS && we0_i && writable(32'(waddr0_i), DEPTH, ZERO_REG) &&
               (waddr0_i == raddr_i);
    wr1_hit  = BYPASS && we1_i && writable(32'(waddr1_i), DEPTH, ZERO_REG) &&
               (waddr1_i == raddr_i);
    rdata_d  = '0;
    // Port 1 wins the bypass exactly as it wins the array write.
    if (rd_valid) begin
      if (wr1_hit) begin
        rdata_d = wdata1_i;
      end else if (wr0_hit) begin
        rdata_d = wdata0_i;
      end else begin
        rdata_d = stored_i;
      end
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q <= '0;
      end else if (rd_en_i) begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb_out
    logic unused_sigs;
    assign unused_sigs = ^{clk_i, rst_i, rd_en_i};
    assign rdata_o     = rdata_d;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: two prioritised write ports, NUM_RD read ports, synchronous clear.
// Owns the storage array and write arbitration; read qualification lives in rf_read_port.
module regfile_multiport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          REG_OUT  = 1'b0,
  localparam int unsigned ADDR_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  output logic                     wr_collision
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr0_eff;
  logic              wr1_eff;

  assign wr0_eff      = we0 && writable(32'(waddr0), DEPTH, ZERO_REG);
  assign wr1_eff      = we1 && writable(32'(waddr1), DEPTH, ZERO_REG);
  assign wr_collision = wr0_eff && wr1_eff && (waddr0 == waddr1);

  // Port 1 is checked first so it overrides port 0 on a shared address.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (wr1_eff && (waddr1 == ADDR_W'(r))) begin
        mem_d[r] = wdata1;
      end else if (wr0_eff && (waddr0 == ADDR_W'(r))) begin
        mem_d[r] = wdata0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] raddr_p;
    logic [DATA_W-1:0] stored_p;

    assign raddr_p = raddr[p*ADDR_W +: ADDR_W];

    // Explicit decode keeps out-of-range addresses from indexing past the array.
    always_comb begin
      stored_p = '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (raddr_p == ADDR_W'(r)) stored_p = mem_q[r];
      end
    end

    rf_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .REG_OUT (REG_OUT)
    ) u_rd (
      .clk_i   (clk),
      .rst_i   (reset),
      .raddr_i (raddr_p),
      .rd_en_i (rd_en[p]),
      .stored_i(stored_p),
      .we0_i   (we0),
      .waddr0_i(waddr0),
      .wdata0_i(wdata0),
      .we1_i   (we1),
      .waddr1_i(waddr1),
      .wdata1_i(wdata1),
      .rdata_o (rdata[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench driving four configurations of regfile_multiport from shared write ports.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [1:0]  rd_en;
  logic [14:0] raddr_c;
  logic [2:0]  rd_en_c;
  logic [63:0] rdata_a, rdata_b, rdata_d;
  logic [95:0] rdata_c;
  logic        coll_a, coll_b, coll_c, coll_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: bypass, b: no bypass, c: registered 3-port, d: DEPTH=20
  regfile_multiport #(.ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .raddr(raddr), .rd_en(rd_en), .rdata(rdata_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .wr_collision(coll_a)
  );

  regfile_multiport #(.ZERO_REG(1'b1), .BYPASS(1'b0), .REG_OUT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .raddr(raddr), .rd_en(rd_en), .rdata(rdata_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .wr_collision(coll_b)
  );

  regfile_multiport #(.NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b1)) dut_c (
    .clk(clk), .reset(reset), .raddr(raddr_c), .rd_en(rd_en_c), .rdata(rdata_c),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .wr_collision(coll_c)
  );

  regfile_multiport #(.DEPTH(20), .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_OUT(1'b0)) dut_d (
    .clk(clk), .reset(reset), .raddr(raddr), .rd_en(rd_en), .rdata(rdata_d),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .wr_collision(coll_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    raddr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rdata_a[31:0] !== 32'h0) begin
      $display("FAIL reset_state r5: got %h expected %h", rdata_a[31:0], 32'h0);
      n_fail++;
    end
    n_checks++;
    if (rdata_c !== 96'h0) begin
      $display("FAIL reset_state regout: got %h expected %h", rdata_c, 96'h0);
      n_fail++;
    end
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    we0 = 1'b0;
    #1;
    n_checks++;
    if (rdata_b[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL write_r5: got %h expected %h", rdata_b[31:0], 32'hDEADBEEF);
      n_fail++;
    end
    reset = 1'b1; we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
    raddr = {5'd7, 5'd5};
    tick();
    reset = 1'b0; we0 = 1'b0;
    #1;
    n_checks++;
    if (rdata_b !== 64'h0) begin
      $display("FAIL reset_clears r5/r7: got %h expected %h", rdata_b, 64'h0);
      n_fail++;
    end
  endtask

  task automatic test_zero_write();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1;
    tick();
    waddr0 = 5'd8; wdata0 = 32'h0;
    tick();
    wdata0 = 32'hA5;
    tick();
    we0 = 1'b0;
    raddr = {5'd8, 5'd0};
    #1;
    n_checks++;
    if (rdata_b !== {32'hA5, 32'h0}) begin
      $display("FAIL zero_reg_write: got %h expected %h", rdata_b, {32'hA5, 32'h0});
      n_fail++;
    end
  endtask

  task automatic test_collision();
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd3; waddr1 = 5'd3;
    wdata0 = 32'h11; wdata1 = 32'h22;
    raddr = {5'd3, 5'd3};
    #1;
    n_checks++;
    if (coll_a !== 1'b1) begin
      $display("FAIL collision_flag r3: got %b expected %b", coll_a, 1'b1);
      n_fail++;
    end
    n_checks++;
    if (rdata_a[31:0] !== 32'h22) begin
      $display("FAIL collision_bypass: got %h expected %h", rdata_a[31:0], 32'h22);
      n_fail++;
    end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    n_checks++;
    if (rdata_b[31:0] !== 32'h22) begin
      $display("FAIL collision_store r3: got %h expected %h", rdata_b[31:0], 32'h22);
      n_fail++;
    end
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd0; waddr1 = 5'd0;
    raddr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (coll_a !== 1'b0) begin
      $display("FAIL collision_flag r0: got %b expected %b", coll_a, 1'b0);
      n_fail++;
    end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    n_checks++;
    if (rdata_a[31:0] !== 32'h0) begin
      $display("FAIL collision_r0: got %h expected %h", rdata_a[31:0], 32'h0);
      n_fail++;
    end
    we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd10; waddr1 = 5'd11;
    wdata0 = 32'hAA; wdata1 = 32'hBB;
    #1;
    n_checks++;
    if (coll_a !== 1'b0) begin
      $display("FAIL collision_flag distinct: got %b expected %b", coll_a, 1'b0);
      n_fail++;
    end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    raddr = {5'd11, 5'd10};
    #1;
    n_checks++;
    if (rdata_b !== {32'hBB, 32'hAA}) begin
      $display("FAIL dual_write: got %h expected %h", rdata_b, {32'hBB, 32'hAA});
      n_fail++;
    end
  endtask

  task automatic test_bypass();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55;
    tick();
    wdata0 = 32'h66;
    raddr = {5'd0, 5'd9};
    #1;
    n_checks++;
    if (rdata_a[31:0] !== 32'h66) begin
      $display("FAIL bypass_on: got %h expected %h", rdata_a[31:0], 32'h66);
      n_fail++;
    end
    n_checks++;
    if (rdata_b[31:0] !== 32'h55) begin
      $display("FAIL bypass_off pre-edge: got %h expected %h", rdata_b[31:0], 32'h55);
      n_fail++;
    end
    tick();
    we0 = 1'b0;
    #1;
    n_checks++;
    if (rdata_b[31:0] !== 32'h66) begin
      $display("FAIL bypass_off post-edge: got %h expected %h", rdata_b[31:0], 32'h66);
      n_fail++;
    end
  endtask

  task automatic test_reg_out();
    // r3 holds 0x22 from the collision test; load it into all three outputs.
    raddr_c = {5'd3, 5'd3, 5'd3};
    rd_en_c = 3'b111;
    #1;
    n_checks++;
    if (rdata_c !== 96'h0) begin
      $display("FAIL regout_latency: got %h expected %h", rdata_c, 96'h0);
      n_fail++;
    end
    tick();
    rd_en_c = 3'b000;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    tick();
    we0 = 1'b0;
    raddr_c = {5'd4, 5'd4, 5'd4};
    rd_en_c = 3'b101;
    tick();
    rd_en_c = 3'b000;
    n_checks++;
    if (rdata_c !== {32'h44, 32'h22, 32'h44}) begin
      $display("FAIL regout_enable: got %h expected %h", rdata_c, {32'h44, 32'h22, 32'h44});
      n_fail++;
    end
    we0 = 1'b1; wdata0 = 32'h99;
    tick();
    tick();
    we0 = 1'b0;
    n_checks++;
    if (rdata_c !== {32'h44, 32'h22, 32'h44}) begin
      $display("FAIL regout_hold: got %h expected %h", rdata_c, {32'h44, 32'h22, 32'h44});
      n_fail++;
    end
    we0 = 1'b1; wdata0 = 32'hAB;
    rd_en_c = 3'b111;
    tick();
    we0 = 1'b0; rd_en_c = 3'b000;
    n_checks++;
    if (rdata_c !== {32'hAB, 32'hAB, 32'hAB}) begin
      $display("FAIL regout_bypass: got %h expected %h", rdata_c, {32'hAB, 32'hAB, 32'hAB});
      n_fail++;
    end
  endtask

  task automatic test_depth20();
    we0 = 1'b1; waddr0 = 5'd25; wdata0 = 32'h2525;
    we1 = 1'b1; waddr1 = 5'd25; wdata1 = 32'h2626;
    raddr = {5'd0, 5'd25};
    #1;
    n_checks++;
    if (coll_d !== 1'b0 || coll_a !== 1'b1) begin
      $display("FAIL depth20_collision: got d=%b a=%b expected d=0 a=1", coll_d, coll_a);
      n_fail++;
    end
    n_checks++;
    if (rdata_d[31:0] !== 32'h0) begin
      $display("FAIL depth20_bypass_oor: got %h expected %h", rdata_d[31:0], 32'h0);
      n_fail++;
    end
    tick();
    we1 = 1'b0;
    waddr0 = 5'd19; wdata0 = 32'h1919;
    #1;
    n_checks++;
    if (rdata_d[31:0] !== 32'h0) begin
      $display("FAIL depth20_read_oor: got %h expected %h", rdata_d[31:0], 32'h0);
      n_fail++;
    end
    tick();
    we0 = 1'b0;
    raddr = {5'd19, 5'd19};
    #1;
    n_checks++;
    if (rdata_d !== {32'h1919, 32'h1919}) begin
      $display("FAIL depth20_r19: got %h expected %h", rdata_d, {32'h1919, 32'h1919});
      n_fail++;
    end
  endtask

  initial begin
    reset = 1'b1;
    we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr = '0; rd_en = '0; raddr_c = '0; rd_en_c = '0;
    test_reset();
    test_zero_write();
    test_collision();
    test_bypass();
    test_reg_out();
    test_depth20();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
